vxe_txn_req_codec: RTL and testbench

- Registered request-transaction codec for the VxEngine memory interface.
- Encode path packs request fields (txn ID, read/not-write, address, data, byte enables) into two vectors:
  - a 44-bit transaction/address vector;
  - a 72-bit data vector.
- Also emits an address-only copy of the transaction vector for channels that carry no data.
- Decode path unpacks a received vector pair back into fields.
- Sits between bus masters/slaves and the interconnect request channels.

---
 rtl/vxe_txn_pkg.sv | 55 +++++
 rtl/vxe_txn_req_pack.sv | 13 +
 rtl/vxe_txn_req_codec.sv | 93 +++++++++
 tb/tb_vxe_txn_req_codec.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vxe_txn_pkg.sv
// Shared widths, field positions and pack/unpack helpers for VxEngine
// request-transaction vectors.
package vxe_txn_pkg;

  localparam int TXNID_W = 6;
  localparam int ADDR_W  = 37;
  localparam int DATA_W  = 64;
  localparam int BEN_W   = DATA_W / 8;
  localparam int TXN_W   = TXNID_W + 1 + ADDR_W;
  localparam int DAT_W   = DATA_W + BEN_W;

  // Transaction vector: {txnid, rnw, addr}; data vector: {data, ben}.
  localparam int ADDR_LSB  = 0;
  localparam int RNW_BIT   = ADDR_LSB + ADDR_W;
  localparam int TXNID_LSB = RNW_BIT + 1;
  localparam int BEN_LSB   = 0;
  localparam int DATA_LSB  = BEN_LSB + BEN_W;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               rnw;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [BEN_W-1:0]   ben;
  } req_fields_t;

  function automatic logic [TXN_W-1:0] pack_txn(input req_fields_t f);
    logic [TXN_W-1:0] v;
    v                            = '0;
    v[TXNID_LSB +: TXNID_W]      = f.txnid;
    v[RNW_BIT]                   = f.rnw;
    v[ADDR_LSB +: ADDR_W]        = f.addr;
    return v;
  endfunction

  function automatic logic [DAT_W-1:0] pack_dat(input req_fields_t f);
    logic [DAT_W-1:0] v;
    v                       = '0;
    v[DATA_LSB +: DATA_W]   = f.data;
    v[BEN_LSB +: BEN_W]     = f.ben;
    return v;
  endfunction

  function automatic req_fields_t unpack(input logic [TXN_W-1:0] txn,
                                         input logic [DAT_W-1:0] dat);
    req_fields_t f;
    f.txnid = txn[TXNID_LSB +: TXNID_W];
    f.rnw   = txn[RNW_BIT];
    f.addr  = txn[ADDR_LSB +: ADDR_W];
    f.data  = dat[DATA_LSB +: DATA_W];
    f.ben   = dat[BEN_LSB +: BEN_W];
    return f;
  endfunction

endpackage

// File: rtl/vxe_txn_req_pack.sv
// Combinational field-to-vector mapping for a request transaction.
module vxe_txn_req_pack
  import vxe_txn_pkg::*;
(
  input  req_fields_t      fields_i,
  output logic [TXN_W-1:0] txn_o,
  output logic [DAT_W-1:0] dat_o
);

  assign txn_o = pack_txn(fields_i);
  assign dat_o = pack_dat(fields_i);

endmodule

// File: rtl/vxe_txn_req_codec.sv
// Registered request codec: independent 1-cycle encode and decode paths
// between request fields and {transaction, data} vector pairs.
module vxe_txn_req_codec
  import vxe_txn_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,

  input  logic               i_enc_vld,
  input  logic [TXNID_W-1:0] i_txnid,
  input  logic               i_rnw,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [BEN_W-1:0]   i_ben,
  output logic               o_enc_vld,
  output logic [TXN_W-1:0]   o_req_vec_txn,
  output logic [DAT_W-1:0]   o_req_vec_dat,
  output logic [TXN_W-1:0]   o_reqa_vec_txn,

  input  logic               i_dec_vld,
  input  logic [TXN_W-1:0]   i_req_vec_txn,
  input  logic [DAT_W-1:0]   i_req_vec_dat,
  output logic               o_dec_vld,
  output logic [TXNID_W-1:0] o_txnid,
  output logic               o_rnw,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_data,
  output logic [BEN_W-1:0]   o_ben
);

  req_fields_t      enc_fields;
  logic [TXN_W-1:0] enc_txn_d, enc_txn_q;
  logic [DAT_W-1:0] enc_dat_d, enc_dat_q;
  logic             enc_vld_q;

  req_fields_t      dec_fields_d, dec_fields_q;
  logic             dec_vld_q;

  assign enc_fields = '{txnid: i_txnid, rnw: i_rnw, addr: i_addr,
                        data: i_data, ben: i_ben};

  vxe_txn_req_pack u_pack (
    .fields_i (enc_fields),
    .txn_o    (enc_txn_d),
    .dat_o    (enc_dat_d)
  );

  assign dec_fields_d = unpack(i_req_vec_txn, i_req_vec_dat);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; payload registers are reset too, because all
  // outputs must read zero while nrst is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      enc_vld_q <= 1'b0;
      enc_txn_q <= '0;
      enc_dat_q <= '0;
    end else begin
      enc_vld_q <= i_enc_vld;
      if (i_enc_vld) begin
        enc_txn_q <= enc_txn_d;
        enc_dat_q <= enc_dat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec_vld_q    <= 1'b0;
      dec_fields_q <= '0;
    end else begin
      dec_vld_q <= i_dec_vld;
      if (i_dec_vld) begin
        dec_fields_q <= dec_fields_d;
      end
    end
  end

  // Address-only channel shares the transaction register, so it can never
  // diverge from the full-request vector.
  assign o_enc_vld      = enc_vld_q;
  assign o_req_vec_txn  = enc_txn_q;
  assign o_reqa_vec_txn = enc_txn_q;
  assign o_req_vec_dat  = enc_dat_q;

  assign o_dec_vld = dec_vld_q;
  assign o_txnid   = dec_fields_q.txnid;
  assign o_rnw     = dec_fields_q.rnw;
  assign o_addr    = dec_fields_q.addr;
  assign o_data    = dec_fields_q.data;
  assign o_ben     = dec_fields_q.ben;

endmodule

// File: tb/tb_vxe_txn_req_codec.sv
// Self-checking bench for vxe_txn_req_codec: directed vectors, async reset,
// and randomized encode->decode loopback against an arithmetic model.
module tb_vxe_txn_req_codec;

  logic         clk;
  logic         nrst;
  logic         i_enc_vld;
  logic [5:0]   i_txnid;
  logic         i_rnw;
  logic [36:0]  i_addr;
  logic [63:0]  i_data;
  logic [7:0]   i_ben;
  logic         o_enc_vld;
  logic [43:0]  o_req_vec_txn;
  logic [71:0]  o_req_vec_dat;
  logic [43:0]  o_reqa_vec_txn;
  logic         i_dec_vld;
  logic [43:0]  i_req_vec_txn;
  logic [71:0]  i_req_vec_dat;
  logic         o_dec_vld;
  logic [5:0]   o_txnid;
  logic         o_rnw;
  logic [36:0]  o_addr;
  logic [63:0]  o_data;
  logic [7:0]   o_ben;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit [5:0]  txnid;
    bit        rnw;
    bit [36:0] addr;
    bit [63:0] data;
    bit [7:0]  ben;
  } fld_t;

  vxe_txn_req_codec dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_enc_vld      (i_enc_vld),
    .i_txnid        (i_txnid),
    .i_rnw          (i_rnw),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .i_ben          (i_ben),
    .o_enc_vld      (o_enc_vld),
    .o_req_vec_txn  (o_req_vec_txn),
    .o_req_vec_dat  (o_req_vec_dat),
    .o_reqa_vec_txn (o_reqa_vec_txn),
    .i_dec_vld      (i_dec_vld),
    .i_req_vec_txn  (i_req_vec_txn),
    .i_req_vec_dat  (i_req_vec_dat),
    .o_dec_vld      (o_dec_vld),
    .o_txnid        (o_txnid),
    .o_rnw          (o_rnw),
    .o_addr         (o_addr),
    .o_data         (o_data),
    .o_ben          (o_ben)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packing by weighted sums: txnid*2^38 + rnw*2^37 + addr.
  function automatic logic [43:0] ref_txn(input fld_t f);
    logic [63:0] v;
    v = 64'(f.txnid) * 64'h40_0000_0000 + 64'(f.rnw) * 64'h20_0000_0000
        + 64'(f.addr);
    return v[43:0];
  endfunction

  function automatic logic [71:0] ref_dat(input fld_t f);
    return 72'(f.data) * 72'd256 + 72'(f.ben);
  endfunction

  function automatic fld_t rand_fld();
    fld_t        f;
    logic [63:0] a;
    a       = {$urandom, $urandom};
    f.txnid = 6'($urandom);
    f.rnw   = 1'($urandom);
    f.addr  = a[36:0];
    f.data  = {$urandom, $urandom};
    f.ben   = 8'($urandom);
    return f;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_enc(input fld_t f, input logic vld);
    i_enc_vld = vld;
    i_txnid   = f.txnid;
    i_rnw     = f.rnw;
    i_addr    = f.addr;
    i_data    = f.data;
    i_ben     = f.ben;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enc_vld"}, 128'(o_enc_vld), 128'd0);
    check({tag, "_txn"},     128'(o_req_vec_txn), 128'd0);
    check({tag, "_reqa"},    128'(o_reqa_vec_txn), 128'd0);
    check({tag, "_dat"},     128'(o_req_vec_dat), 128'd0);
    check({tag, "_dec_vld"}, 128'(o_dec_vld), 128'd0);
    check({tag, "_dec"},     128'({o_txnid, o_rnw, o_addr, o_data, o_ben}), 128'd0);
  endtask

  initial begin
    fld_t f, m_enc, m_dec, zero_f;
    logic m_enc_vld, m_dec_vld, v;

    zero_f = '{txnid: 0, rnw: 0, addr: 0, data: 0, ben: 0};

    // Reset held with live random inputs and both valids high.
    nrst = 1'b0;
    drive_enc(rand_fld(), 1'b1);
    i_dec_vld     = 1'b1;
    i_req_vec_txn = 44'($urandom);
    i_req_vec_dat = 72'($urandom);
    repeat (3) tick();
    check_all_zero("reset");
    nrst = 1'b1;

    // Encode write.
    f = '{txnid: 6'h3f, rnw: 1'b0, addr: 37'h03_0303_0303,
          data: 64'hfefe_fafa_dada_dede, ben: 8'h33};
    drive_enc(f, 1'b1);
    i_dec_vld = 1'b0;
    tick();
    check("wr_enc_vld", 128'(o_enc_vld), 128'd1);
    check("wr_txn",     128'(o_req_vec_txn), 128'h0FC3_0303_0303);
    check("wr_reqa",    128'(o_reqa_vec_txn), 128'h0FC3_0303_0303);
    check("wr_dat",     128'(o_req_vec_dat), 128'hfe_fefa_fada_dade_de33);
    check("wr_dec_vld", 128'(o_dec_vld), 128'd0);

    // Encode read: ben/data still carried.
    f = '{txnid: 6'h2a, rnw: 1'b1, addr: 37'h1f_1313_1313,
          data: 64'hdede_dada_fafa_fefe, ben: 8'h11};
    drive_enc(f, 1'b1);
    tick();
    check("rd_enc_vld", 128'(o_enc_vld), 128'd1);
    check("rd_txn",     128'(o_req_vec_txn), 128'h0ABF_1313_1313);
    check("rd_reqa",    128'(o_reqa_vec_txn), 128'h0ABF_1313_1313);
    check("rd_dat",     128'(o_req_vec_dat), 128'hde_deda_dafa_fafe_fe11);

    // Decode alongside an encode hold (new inputs, i_enc_vld=0).
    drive_enc(rand_fld(), 1'b0);
    i_dec_vld     = 1'b1;
    i_req_vec_txn = 44'hABF_1313_1313;
    i_req_vec_dat = 72'hde_deda_dafa_fafe_fe11;
    tick();
    check("dec_vld",    128'(o_dec_vld), 128'd1);
    check("dec_txnid",  128'(o_txnid), 128'h2a);
    check("dec_rnw",    128'(o_rnw), 128'd1);
    check("dec_addr",   128'(o_addr), 128'h1f_1313_1313);
    check("dec_data",   128'(o_data), 128'hdede_dada_fafa_fefe);
    check("dec_ben",    128'(o_ben), 128'h11);
    check("hold_vld",   128'(o_enc_vld), 128'd0);
    check("hold_txn",   128'(o_req_vec_txn), 128'h0ABF_1313_1313);
    check("hold_reqa",  128'(o_reqa_vec_txn), 128'h0ABF_1313_1313);
    check("hold_dat",   128'(o_req_vec_dat), 128'hde_deda_dafa_fafe_fe11);

    // Decode hold: new vectors ignored while i_dec_vld=0.
    i_dec_vld     = 1'b0;
    i_req_vec_txn = 44'h123_4567_89ab;
    i_req_vec_dat = 72'h55_aa55_aa55_aa55_aa55;
    tick();
    check("dhold_vld",  128'(o_dec_vld), 128'd0);
    check("dhold_dec",  128'({o_txnid, o_rnw, o_addr, o_data, o_ben}),
          128'({6'h2a, 1'b1, 37'h1f_1313_1313, 64'hdede_dada_fafa_fefe, 8'h11}));

    // Reset asserted mid-operation, checked before any further clock edge.
    drive_enc(rand_fld(), 1'b1);
    i_dec_vld = 1'b1;
    tick();
    check("pre_rst_enc_vld", 128'(o_enc_vld), 128'd1);
    #2 nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    nrst = 1'b1;

    // Randomized loopback: decoder fed from encoder outputs.
    m_enc_vld = 1'b0;
    m_dec_vld = 1'b0;
    m_enc     = zero_f;
    m_dec     = zero_f;
    i_dec_vld = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      f = rand_fld();
      v = ($urandom_range(3) != 0);
      drive_enc(f, v);
      i_dec_vld     = o_enc_vld;
      i_req_vec_txn = o_req_vec_txn;
      i_req_vec_dat = o_req_vec_dat;

      m_dec_vld = m_enc_vld;
      if (m_enc_vld) m_dec = m_enc;
      m_enc_vld = v;
      if (v) m_enc = f;

      tick();
      check("lb_enc_vld", 128'(o_enc_vld), 128'(m_enc_vld));
      check("lb_txn",     128'(o_req_vec_txn), 128'(ref_txn(m_enc)));
      check("lb_reqa",    128'(o_reqa_vec_txn), 128'(o_req_vec_txn));
      check("lb_dat",     128'(o_req_vec_dat), 128'(ref_dat(m_enc)));
      check("lb_dec_vld", 128'(o_dec_vld), 128'(m_dec_vld));
      check("lb_txnid",   128'(o_txnid), 128'(m_dec.txnid));
      check("lb_rnw",     128'(o_rnw), 128'(m_dec.rnw));
      check("lb_addr",    128'(o_addr), 128'(m_dec.addr));
      check("lb_data",    128'(o_data), 128'(m_dec.data));
      check("lb_ben",     128'(o_ben), 128'(m_dec.ben));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
